// File: rtl/bus_arbiter2.sv
// Two-requester burst arbiter with a registered shared data path.
// Tie break in IDLE is round-robin via a last-served pointer; a requester
// keeps its grant until its last beat or until it drops req.
// Optional feature: define ARB_TIMEOUT_EN to force-release a grant after
// TIMEOUT_CYCLES beats while the other requester is waiting.
module bus_arbiter2 #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             reqA,
  input  logic             reqB,
  input  logic             lastA,
  input  logic             lastB,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             gntA,
  output logic             gntB,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntA = 2'd1,
    StGntB = 2'd2
  } state_e;

  // Elaboration guard: a zero grant limit has no meaning.
  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bus_arbiter2: TIMEOUT_CYCLES must be at least 1");
  end

  state_e           state_q;
  logic             last_a_q;     // 1: A was served last, 0: B was served last
  logic             in_grant;
  logic             cur_req;
  logic             cur_last;
  logic             other_req;
  logic             other_is_a;
  logic [WIDTH-1:0] cur_in;
  logic             beat;
  logic             force_rel;
  logic             release_now;
  logic             pick_a;
  logic             grant_now;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
`endif

  // Decode the current grant owner, beat and release conditions.
  always_comb begin
    in_grant   = (state_q == StGntA) || (state_q == StGntB);
    cur_req    = (state_q == StGntA) ? reqA  : reqB;
    cur_last   = (state_q == StGntA) ? lastA : lastB;
    cur_in     = (state_q == StGntA) ? inA   : inB;
    other_req  = (state_q == StGntA) ? reqB  : reqA;
    other_is_a = (state_q == StGntB);
    beat       = in_grant && cur_req;
`ifdef ARB_TIMEOUT_EN
    // Saturating increment; the limit only bites while the other side waits.
    cnt_inc    = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    force_rel  = beat && other_req && (cnt_inc == CntMax);
`else
    force_rel  = 1'b0;
`endif
    // A dropped req releases without a beat; lastx with reqx=0 is ignored.
    release_now = in_grant && (!cur_req || cur_last || force_rel);
    // Tie goes to the requester not named by the last-served pointer.
    pick_a      = reqA && (!reqB || !last_a_q);
    grant_now   = ((state_q == StIdle) && (reqA || reqB)) || (release_now && other_req);
  end

  // Arbiter FSM with registered grants, select and data path.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      gntA      <= 1'b0;
      gntB      <= 1'b0;
      sel       <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      last_a_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          out_valid <= 1'b0;
          if (pick_a) begin
            state_q <= StGntA;
            gntA    <= 1'b1;
            gntB    <= 1'b0;
            sel     <= 1'b1;
          end else if (reqB) begin
            state_q <= StGntB;
            gntA    <= 1'b0;
            gntB    <= 1'b1;
            sel     <= 1'b0;
          end
        end
        StGntA, StGntB: begin
          out_valid <= beat;
          if (beat) begin
            out <= cur_in;
          end
          if (release_now) begin
            last_a_q <= (state_q == StGntA);
            // Hand over directly; the same requester never re-grants without IDLE.
            if (other_req) begin
              state_q <= other_is_a ? StGntA : StGntB;
              gntA    <= other_is_a;
              gntB    <= !other_is_a;
              sel     <= other_is_a;
            end else begin
              state_q <= StIdle;
              gntA    <= 1'b0;
              gntB    <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          gntA      <= 1'b0;
          gntB      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Beat counter: cleared on every new grant, counts beats of the current owner.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (grant_now) begin
      cnt_q <= '0;
    end else if (beat) begin
      cnt_q <= cnt_inc;
    end
  end
`else
  // Without the timeout feature the grant indicator has no consumer.
  logic unused_grant_now;
  assign unused_grant_now = grant_now;
`endif

endmodule
